// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, sequencer states and square range.
// Used by the game controller and the VGA renderer.
package ttt_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [7:0] SQ_MIN    = 8'd1;
    localparam logic [7:0] SQ_MAX    = 8'd9;
    localparam int         NUM_CELLS = 9;
    localparam logic [3:0] MAX_MOVES = 4'd9;

    function automatic logic [1:0] player_code(input logic player);
        return player ? CELL_P2 : CELL_P1;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector: flags whether the given mark owns any
// of the 3 rows, 3 columns or 2 diagonals of the board.
module ttt_line_check (
    input  logic [17:0] board,
    input  logic [1:0]  mark,
    output logic        win
);

    logic [8:0] owned;

    always_comb begin
        owned = '0;
        for (int i = 0; i < 9; i++) begin
            owned[i] = (board[2*i +: 2] == mark);
        end
    end

    assign win = (&owned[2:0]) | (&owned[5:3]) | (&owned[8:6])
               | (owned[0] & owned[3] & owned[6])
               | (owned[1] & owned[4] & owned[7])
               | (owned[2] & owned[5] & owned[8])
               | (owned[0] & owned[4] & owned[8])
               | (owned[2] & owned[4] & owned[6]);

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: owns the board, alternates turns, rejects illegal moves, detects win/draw.
// Optional per-move forfeit timer enabled by defining TTT_TURN_TIMEOUT_EN.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic        FIRST_PLAYER   = 1'b0,
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd250000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        select,
    input  logic [7:0]  square_num,
    output logic [17:0] board,
    output logic        cur_player,
    output logic [3:0]  move_count,
    output logic        move_reject,
    output logic        player_1_win,
    output logic        player_2_win,
    output logic        draw,
    output logic        game_over
);

    state_t      state_q, state_n;
    logic [17:0] board_q, board_n;
    logic        cur_q, cur_n;
    logic [3:0]  cnt_q, cnt_n;
    logic        rej_q, rej_n;
    logic        p1_q, p1_n;
    logic        p2_q, p2_n;
    logic        draw_q, draw_n;

    logic        in_range;
    logic [3:0]  cell_idx;
    logic [1:0]  sel_cell;
    logic        legal;
    logic [1:0]  mover;
    logic        mover_wins;

    assign mover    = player_code(cur_q);
    assign in_range = (square_num >= SQ_MIN) && (square_num <= SQ_MAX);
    assign cell_idx = square_num[3:0] - 4'd1;

    always_comb begin
        sel_cell = CELL_EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_idx == 4'(i)) sel_cell = board_q[2*i +: 2];
        end
    end

    assign legal = in_range && (sel_cell == CELL_EMPTY);

    // The registered board already holds the new mark by the time CHECK runs.
    ttt_line_check u_line_check (
        .board (board_q),
        .mark  (mover),
        .win   (mover_wins)
    );

`ifdef TTT_TURN_TIMEOUT_EN
    logic [27:0] timer_q, timer_n;
    logic        timeout_hit;

    assign timeout_hit = (state_q == S_TURN) && !start && !select
                       && (timer_q == TIMEOUT_CYCLES - 28'd1);

    always_comb begin
        timer_n = timer_q + 28'd1;
        if (start || select || timeout_hit || (state_q != S_TURN)) timer_n = '0;
    end

    always_ff @(posedge clk) begin
        if (clr) timer_q <= '0;
        else     timer_q <= timer_n;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            board_q <= '0;
            cur_q   <= FIRST_PLAYER;
            cnt_q   <= '0;
            rej_q   <= 1'b0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            draw_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            board_q <= board_n;
            cur_q   <= cur_n;
            cnt_q   <= cnt_n;
            rej_q   <= rej_n;
            p1_q    <= p1_n;
            p2_q    <= p2_n;
            draw_q  <= draw_n;
        end
    end

    // start overrides everything, including a same-cycle select or a pending CHECK.
    always_comb begin
        state_n = state_q;
        board_n = board_q;
        cur_n   = cur_q;
        cnt_n   = cnt_q;
        rej_n   = 1'b0;
        p1_n    = p1_q;
        p2_n    = p2_q;
        draw_n  = draw_q;

        if (start) begin
            state_n = S_TURN;
            board_n = '0;
            cur_n   = FIRST_PLAYER;
            cnt_n   = '0;
            p1_n    = 1'b0;
            p2_n    = 1'b0;
            draw_n  = 1'b0;
        end else begin
            case (state_q)
                S_TURN: begin
                    if (select) begin
                        if (legal) begin
                            for (int i = 0; i < NUM_CELLS; i++) begin
                                if (cell_idx == 4'(i)) board_n[2*i +: 2] = mover;
                            end
                            cnt_n   = (cnt_q == MAX_MOVES) ? cnt_q : cnt_q + 4'd1;
                            state_n = S_CHECK;
                        end else begin
                            rej_n = 1'b1;
                        end
                    end
`ifdef TTT_TURN_TIMEOUT_EN
                    else if (timeout_hit) begin
                        cur_n = ~cur_q;
                    end
`endif
                end
                S_CHECK: begin
                    if (mover_wins) begin
                        if (cur_q) p2_n = 1'b1;
                        else       p1_n = 1'b1;
                        state_n = S_OVER;
                    end else if (cnt_q == MAX_MOVES) begin
                        draw_n  = 1'b1;
                        state_n = S_OVER;
                    end else begin
                        cur_n   = ~cur_q;
                        state_n = S_TURN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign board        = board_q;
    assign cur_player   = cur_q;
    assign move_count   = cnt_q;
    assign move_reject  = rej_q;
    assign player_1_win = p1_q;
    assign player_2_win = p2_q;
    assign draw         = draw_q;
    assign game_over    = (state_q == S_OVER);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl against a cell-array game model.
// The forfeit-timer scenario runs only when TTT_TURN_TIMEOUT_EN is defined.
module tb_ttt_game_ctrl;

    localparam logic        FP  = 1'b0;
    localparam logic [27:0] TMO = 28'd16;

    logic        clk = 1'b0;
    logic        clr, start, select;
    logic [7:0]  square_num;
    logic [17:0] board;
    logic        cur_player, move_reject, player_1_win, player_2_win, draw, game_over;
    logic [3:0]  move_count;

    ttt_game_ctrl #(.FIRST_PLAYER(FP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .clr(clr), .start(start), .select(select), .square_num(square_num),
        .board(board), .cur_player(cur_player), .move_count(move_count),
        .move_reject(move_reject), .player_1_win(player_1_win),
        .player_2_win(player_2_win), .draw(draw), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Game model: cells hold 0 empty, 1 P1, 2 P2; mode 0 idle, 1 playing, 2 over.
    int   m_cells [9];
    logic m_cur;
    int   m_count;
    logic m_p1, m_p2, m_draw;
    int   m_mode;
    int   win_lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    logic [26:0] dut_pack;
    assign dut_pack = {board, cur_player, move_count, player_1_win, player_2_win, draw, game_over};

    function automatic void model_reset();
        foreach (m_cells[i]) m_cells[i] = 0;
        m_cur = FP; m_count = 0; m_p1 = 0; m_p2 = 0; m_draw = 0; m_mode = 0;
    endfunction

    function automatic void model_start();
        model_reset();
        m_mode = 1;
    endfunction

    function automatic logic model_wins(input int code);
        for (int l = 0; l < 8; l++) begin
            if (m_cells[win_lines[l][0]] == code && m_cells[win_lines[l][1]] == code &&
                m_cells[win_lines[l][2]] == code) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic model_select(input int sq);
        int code;
        if (m_mode != 1) return 1'b0;
        if (sq < 1 || sq > 9 || m_cells[sq-1] != 0) return 1'b1;
        code = m_cur ? 2 : 1;
        m_cells[sq-1] = code;
        m_count++;
        if (model_wins(code)) begin
            if (code == 1) m_p1 = 1'b1; else m_p2 = 1'b1;
            m_mode = 2;
        end else if (m_count == 9) begin
            m_draw = 1'b1;
            m_mode = 2;
        end else begin
            m_cur = ~m_cur;
        end
        return 1'b0;
    endfunction

    function automatic logic [26:0] model_pack();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cells[i]);
        return {b, m_cur, 4'(m_count), m_p1, m_p2, m_draw, (m_mode == 2)};
    endfunction

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_select(input int sq);
        @(negedge clk); square_num = 8'(sq); select = 1'b1;
        @(negedge clk); select = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        model_reset();
        n_vec++;
        if ({move_reject, dut_pack} !== {1'b0, model_pack()}) begin
            n_err++;
            $display("[TB] FAIL reset: got %h want %h", {move_reject, dut_pack}, {1'b0, model_pack()});
        end
    endtask

    task automatic test_p1_row_win();
        int   s[$] = '{1, 4, 2, 5, 3};
        logic exp_rej;
        do_start(); model_start();
        foreach (s[i]) begin
            pulse_select(s[i]); exp_rej = model_select(s[i]); n_vec++;
            if (move_reject !== exp_rej) begin
                n_err++; $display("[TB] FAIL row_win reject sq=%0d: got %b want %b", s[i], move_reject, exp_rej);
            end
            @(negedge clk); n_vec++;
            if ({move_reject, dut_pack} !== {1'b0, model_pack()}) begin
                n_err++; $display("[TB] FAIL row_win state sq=%0d: got %h want %h", s[i], {move_reject, dut_pack}, {1'b0, model_pack()});
            end
        end
        n_vec++;
        if ({board[5:0], player_1_win, player_2_win, game_over, move_count} !== {6'b010101, 3'b101, 4'd5}) begin
            n_err++; $display("[TB] FAIL row_win final: got %b want %b",
                {board[5:0], player_1_win, player_2_win, game_over, move_count}, {6'b010101, 3'b101, 4'd5});
        end
    endtask

    task automatic test_reject();
        int   s[$] = '{5, 5, 0, 10, 255};
        logic exp_rej;
        do_start(); model_start();
        foreach (s[i]) begin
            pulse_select(s[i]); exp_rej = model_select(s[i]); n_vec++;
            if (move_reject !== exp_rej) begin
                n_err++; $display("[TB] FAIL reject pulse sq=%0d: got %b want %b", s[i], move_reject, exp_rej);
            end
            @(negedge clk); n_vec++;
            if ({move_reject, dut_pack} !== {1'b0, model_pack()}) begin
                n_err++; $display("[TB] FAIL reject state sq=%0d: got %h want %h", s[i], {move_reject, dut_pack}, {1'b0, model_pack()});
            end
        end
        n_vec++;
        if ({board[9:8], cur_player} !== 3'b011) begin
            n_err++; $display("[TB] FAIL reject final: got %b want %b", {board[9:8], cur_player}, 3'b011);
        end
    endtask

    task automatic test_full_board(input logic diag_variant);
        int   s[$];
        logic exp_rej;
        if (diag_variant) s = '{1, 3, 2, 4, 5, 7, 6, 8, 9};
        else              s = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        do_start(); model_start();
        foreach (s[i]) begin
            pulse_select(s[i]); exp_rej = model_select(s[i]); n_vec++;
            if (move_reject !== exp_rej) begin
                n_err++; $display("[TB] FAIL full_board reject sq=%0d: got %b want %b", s[i], move_reject, exp_rej);
            end
            @(negedge clk); n_vec++;
            if ({move_reject, dut_pack} !== {1'b0, model_pack()}) begin
                n_err++; $display("[TB] FAIL full_board state sq=%0d: got %h want %h", s[i], {move_reject, dut_pack}, {1'b0, model_pack()});
            end
        end
        n_vec++;
        if ({move_count, player_1_win, player_2_win, draw, game_over} !==
            {4'd9, diag_variant, 1'b0, !diag_variant, 1'b1}) begin
            n_err++; $display("[TB] FAIL full_board final diag=%b: got %b want %b", diag_variant,
                {move_count, player_1_win, player_2_win, draw, game_over},
                {4'd9, diag_variant, 1'b0, !diag_variant, 1'b1});
        end
    endtask

    task automatic test_start_priority();
        int   s[$] = '{1, 5, 9};
        logic exp_rej;
        do_start(); model_start();
        foreach (s[i]) begin
            pulse_select(s[i]); exp_rej = model_select(s[i]); n_vec++;
            if (move_reject !== exp_rej) begin
                n_err++; $display("[TB] FAIL start_prio reject sq=%0d: got %b want %b", s[i], move_reject, exp_rej);
            end
            @(negedge clk);
        end
        @(negedge clk); start = 1'b1; select = 1'b1; square_num = 8'd3;
        @(negedge clk); start = 1'b0; select = 1'b0;
        model_start();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({move_reject, dut_pack} !== {1'b0, model_pack()}) begin
                n_err++; $display("[TB] FAIL start_prio state k=%0d: got %h want %h", k, {move_reject, dut_pack}, {1'b0, model_pack()});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clr_and_ignored();
        int   s[$] = '{1, 4, 2, 5, 3, 6};
        logic exp_rej;
        do_start(); model_start();
        pulse_select(7);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_reset(); n_vec++;
        if ({move_reject, dut_pack} !== {1'b0, model_pack()}) begin
            n_err++; $display("[TB] FAIL clr_in_check: got %h want %h", {move_reject, dut_pack}, {1'b0, model_pack()});
        end
        pulse_select(3); exp_rej = model_select(3); n_vec++;
        if (move_reject !== exp_rej) begin
            n_err++; $display("[TB] FAIL idle_select reject: got %b want %b", move_reject, exp_rej);
        end
        @(negedge clk); n_vec++;
        if ({move_reject, dut_pack} !== {1'b0, model_pack()}) begin
            n_err++; $display("[TB] FAIL idle_select state: got %h want %h", {move_reject, dut_pack}, {1'b0, model_pack()});
        end
        // Last square arrives after the win, so it exercises select in OVER.
        do_start(); model_start();
        foreach (s[i]) begin
            pulse_select(s[i]); exp_rej = model_select(s[i]); n_vec++;
            if (move_reject !== exp_rej) begin
                n_err++; $display("[TB] FAIL over_select reject sq=%0d: got %b want %b", s[i], move_reject, exp_rej);
            end
            @(negedge clk); n_vec++;
            if ({move_reject, dut_pack} !== {1'b0, model_pack()}) begin
                n_err++; $display("[TB] FAIL over_select state sq=%0d: got %h want %h", s[i], {move_reject, dut_pack}, {1'b0, model_pack()});
            end
        end
    endtask

    task automatic test_random_games();
        int   sq;
        logic exp_rej;
        for (int g = 0; g < 12; g++) begin
            do_start(); model_start();
            for (int k = 0; k < 40 && m_mode == 1; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sq = int'($urandom_range(0, 11));
                pulse_select(sq); exp_rej = model_select(sq); n_vec++;
                if (move_reject !== exp_rej) begin
                    n_err++; $display("[TB] FAIL random g=%0d reject sq=%0d: got %b want %b", g, sq, move_reject, exp_rej);
                end
                @(negedge clk); n_vec++;
                if ({move_reject, dut_pack} !== {1'b0, model_pack()}) begin
                    n_err++; $display("[TB] FAIL random g=%0d state sq=%0d: got %h want %h", g, sq, {move_reject, dut_pack}, {1'b0, model_pack()});
                end
            end
        end
    endtask

`ifdef TTT_TURN_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_rej;
        do_start(); model_start();
        repeat (15) @(negedge clk);
        n_vec++;
        if (dut_pack !== model_pack()) begin
            n_err++; $display("[TB] FAIL timeout early: got %h want %h", dut_pack, model_pack());
        end
        @(negedge clk);
        m_cur = ~m_cur; n_vec++;
        if (dut_pack !== model_pack()) begin
            n_err++; $display("[TB] FAIL timeout forfeit: got %h want %h", dut_pack, model_pack());
        end
        do_start(); model_start();
        repeat (14) @(negedge clk);
        pulse_select(1); exp_rej = model_select(1); n_vec++;
        if ({move_reject, board[1:0]} !== {exp_rej, 2'b01}) begin
            n_err++; $display("[TB] FAIL timeout select: got %b want %b", {move_reject, board[1:0]}, {exp_rej, 2'b01});
        end
        @(negedge clk); n_vec++;
        if (dut_pack !== model_pack()) begin
            n_err++; $display("[TB] FAIL timeout after select: got %h want %h", dut_pack, model_pack());
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr = 1'b1; start = 1'b0; select = 1'b0; square_num = 8'd0;
        test_reset();
        test_p1_row_win();
        test_reject();
        test_full_board(1'b0);
        test_full_board(1'b1);
        test_start_priority();
        test_clr_and_ignored();
        test_random_games();
`ifdef TTT_TURN_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
